// File: rtl/quad_pkg.sv
// Shared encodings for the quadrature emitter: phase codes, FSM states,
// and the signed saturation limits of the pending-step counter.
package quad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  // {sa,sb} per phase; adjacent phases differ in exactly one bit
  localparam logic [1:0] ENC_P0 = 2'b00;
  localparam logic [1:0] ENC_P1 = 2'b10;
  localparam logic [1:0] ENC_P2 = 2'b11;
  localparam logic [1:0] ENC_P3 = 2'b01;

  function automatic logic [1:0] phase_enc(input logic [1:0] ph);
    logic [1:0] enc;
    case (ph)
      PH0:     enc = ENC_P0;
      PH1:     enc = ENC_P1;
      PH2:     enc = ENC_P2;
      PH3:     enc = ENC_P3;
      default: enc = ENC_P0;
    endcase
    return enc;
  endfunction

  function automatic int pend_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int pend_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/quad_tick_gen.sv
// Free-running divide-by-DIV counter with synchronous clear; tick is high for
// the one cycle the counter sits at DIV-1, so the next edge lands DIV cycles after a clear.
module quad_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/quad_encoder_emitter.sv
// Rotary encoder emulator: queues signed detent requests and plays each out as EDGES_PER_STEP
// quadrature edges EDGE_DIV apart, then a quiet gap; stretches press pulses onto sw_out.
module quad_encoder_emitter
  import quad_pkg::*;
#(
  parameter int unsigned EDGE_DIV       = 50000,
  parameter int unsigned EDGES_PER_STEP = 4,
  parameter int unsigned PEND_W         = 8,
  parameter int unsigned PRESS_CYC      = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_cw,
  input  logic              step_ccw,
  input  logic              press,
  input  logic              ovf_clr,
  output logic              sa,
  output logic              sb,
  output logic              sw_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int PCW = $clog2(PRESS_CYC + 1);
  localparam logic signed [PEND_W-1:0] PMAX = PEND_W'(pend_max(PEND_W));
  localparam logic signed [PEND_W-1:0] PMIN = PEND_W'(pend_min(PEND_W));
  localparam logic signed [PEND_W-1:0] PONE = PEND_W'(1);

  state_e                    state_q, state_d;
  logic                      dir_q, dir_d;
  logic [2:0]                edge_cnt_q, edge_cnt_d;
  logic [1:0]                phase_q, phase_d;
  logic                      sa_q, sb_q, sa_d, sb_d;
  logic signed [PEND_W-1:0]  pend_q, pend_d, pend_base;
  logic                      ovf_q, ovf_d;
  logic [PCW-1:0]            press_cnt_q, press_cnt_d;
  logic                      sw_q, sw_d;
  logic                      done, tick, div_clr;

  quad_tick_gen #(.DIV(EDGE_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    edge_cnt_d = edge_cnt_q;
    phase_d    = phase_q;
    done       = 1'b0;
    div_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        div_clr = 1'b1;
        if (pend_q != '0) begin
          dir_d      = ~pend_q[PEND_W-1];
          edge_cnt_d = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick) begin
          phase_d    = dir_q ? phase_q + 2'd1 : phase_q - 2'd1;
          edge_cnt_d = edge_cnt_q + 3'd1;
          if (edge_cnt_q == 3'(EDGES_PER_STEP - 1)) begin
            done    = 1'b1;
            div_clr = 1'b1;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    {sa_d, sb_d} = phase_enc(phase_d);
  end

  // The in-flight detent is still counted in pend_q, so retire it before
  // judging new requests against the limits.
  always_comb begin
    pend_base = pend_q;
    ovf_d     = ovf_q & ~ovf_clr;
    if (done) begin
      if (dir_q) begin
        if (pend_q == PMIN) ovf_d = 1'b1;
        else                pend_base = pend_q - PONE;
      end else begin
        if (pend_q == PMAX) ovf_d = 1'b1;
        else                pend_base = pend_q + PONE;
      end
    end
    pend_d = pend_base;
    if (step_cw && !step_ccw) begin
      if (pend_base == PMAX) ovf_d  = 1'b1;
      else                   pend_d = pend_base + PONE;
    end else if (step_ccw && !step_cw) begin
      if (pend_base == PMIN) ovf_d  = 1'b1;
      else                   pend_d = pend_base - PONE;
    end
  end

  always_comb begin
    press_cnt_d = press_cnt_q;
    if (press) begin
      press_cnt_d = PCW'(PRESS_CYC);
    end else if (press_cnt_q != '0) begin
      press_cnt_d = press_cnt_q - PCW'(1);
    end
    sw_d = (press_cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      dir_q       <= 1'b0;
      edge_cnt_q  <= '0;
      phase_q     <= PH0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      pend_q      <= '0;
      ovf_q       <= 1'b0;
      press_cnt_q <= '0;
      sw_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      edge_cnt_q  <= edge_cnt_d;
      phase_q     <= phase_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      press_cnt_q <= press_cnt_d;
      sw_q        <= sw_d;
    end
  end

  assign sa       = sa_q;
  assign sb       = sb_q;
  assign sw_out   = sw_q;
  assign busy     = (state_q != ST_IDLE);
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_quad_encoder_emitter.sv
// Scoreboarded bench: stimulus queues expected quadrature edges, a negedge monitor
// checks value, single-bit change and spacing, and decodes detents as a loopback.
module tb_quad_encoder_emitter;

  localparam int EDGE_DIV  = 4;
  localparam int EPS       = 4;
  localparam int PEND_W    = 3;
  localparam int PRESS_CYC = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic step_cw = 1'b0, step_ccw = 1'b0, press = 1'b0, ovf_clr = 1'b0;
  logic sa, sb, sw_out, busy, overflow;
  logic [PEND_W-1:0] pending;

  quad_encoder_emitter #(
    .EDGE_DIV(EDGE_DIV), .EDGES_PER_STEP(EPS), .PEND_W(PEND_W), .PRESS_CYC(PRESS_CYC)
  ) dut (
    .clk(clk), .rst(rst), .step_cw(step_cw), .step_ccw(step_ccw), .press(press),
    .ovf_clr(ovf_clr), .sa(sa), .sb(sb), .sw_out(sw_out), .busy(busy),
    .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] ab;
    bit         from_mark;
    int         lo;
    int         hi;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_e;
  int checks = 0, failures = 0;
  int mark_cyc = 0, last_edge_cyc = 0;
  int rights = 0, lefts = 0, acc = 0, gap = 0, dph = 0;
  logic [1:0] prev_ab = 2'b00;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int ph_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Monitor: every change of {sa,sb} must match the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      prev_ab = 2'b00;
      acc     = 0;
    end else if ({sa, sb} !== prev_ab) begin
      chk("single_bit_edge", $countones({sa, sb} ^ prev_ab), 1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_edge actual=%b required=no_edge (cycle %0d)", {sa, sb}, cyc);
      end else begin
        cur_e = exp_q.pop_front();
        chk("edge_value", int'({sa, sb}), int'(cur_e.ab));
        gap = cyc - (cur_e.from_mark ? mark_cyc : last_edge_cyc);
        checks++;
        if (gap < cur_e.lo || gap > cur_e.hi) begin
          failures++;
          $display("FAIL edge_spacing actual=%0d required=%0d..%0d (cycle %0d)",
                   gap, cur_e.lo, cur_e.hi, cyc);
        end
      end
      dph = (ph_idx({sa, sb}) - ph_idx(prev_ab)) & 3;
      if (dph == 1) acc++;
      else if (dph == 3) acc--;
      if ({sa, sb} == 2'b00) begin
        if (acc == 4) rights++;
        else if (acc == -4) lefts++;
        acc = 0;
      end
      last_edge_cyc = cyc;
      prev_ab = {sa, sb};
    end
  end

  task automatic push_edge(input logic [1:0] ab, input bit fm, input int lo, input int hi);
    exp_t e;
    e.ab = ab; e.from_mark = fm; e.lo = lo; e.hi = hi;
    exp_q.push_back(e);
  endtask

  // First edge 6 cycles after the pulse launch, 4 inside a detent, >=8 between detents.
  task automatic push_detents(input int n, input bit cw);
    logic [1:0] ab;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        case (j)
          0: ab = cw ? 2'b10 : 2'b01;
          1: ab = 2'b11;
          2: ab = cw ? 2'b01 : 2'b10;
          default: ab = 2'b00;
        endcase
        if (i == 0 && j == 0)  push_edge(ab, 1'b1, EDGE_DIV + 2, EDGE_DIV + 2);
        else if (j == 0)       push_edge(ab, 1'b0, 2 * EDGE_DIV, 2 * EDGE_DIV + 4);
        else                   push_edge(ab, 1'b0, EDGE_DIV, EDGE_DIV);
      end
    end
  endtask

  task automatic pulse(input bit cw, input bit ccw, input int n);
    @(posedge clk);
    #1;
    mark_cyc = cyc;
    step_cw  = cw;
    step_ccw = ccw;
    repeat (n) @(posedge clk);
    #1;
    step_cw  = 1'b0;
    step_ccw = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy && pending == '0) break;
    end
    checks++;
    if (k == budget) begin
      failures++;
      $display("FAIL %s_timeout actual=busy%0d_pend%0d required=idle", name, busy, pending);
    end
    chk({name, "_edges_left"}, exp_q.size(), 0);
  endtask

  task automatic press_test(input string name, input int repress_at, input int low_len);
    @(posedge clk);
    #1;
    press = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #1;
      press = (k == repress_at);
      @(negedge clk);
      chk(name, int'(sw_out), (k <= low_len) ? 0 : 1);
    end
    press = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, l0, k;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_ab", int'({sa, sb}), 0);
    chk("reset_sw", int'(sw_out), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pend", int'($signed(pending)), 0);
    chk("reset_ovf", int'(overflow), 0);

    // single clockwise detent
    r0 = rights; l0 = lefts;
    push_detents(1, 1'b1);
    pulse(1'b1, 1'b0, 1);
    @(negedge clk);
    chk("cw_pend", int'($signed(pending)), 1);
    @(negedge clk);
    chk("cw_busy", int'(busy), 1);
    wait_idle("cw", 200);
    chk("cw_right", rights - r0, 1);

    // single counter-clockwise detent
    push_detents(1, 1'b0);
    pulse(1'b0, 1'b1, 1);
    @(negedge clk);
    chk("ccw_pend", int'($signed(pending)), -1);
    wait_idle("ccw", 200);
    chk("ccw_left", lefts - l0, 1);
    chk("ccw_pend_end", int'($signed(pending)), 0);

    // three back-to-back clockwise requests
    push_detents(3, 1'b1);
    pulse(1'b1, 1'b0, 3);
    @(negedge clk);
    chk("cw3_pend", int'($signed(pending)), 3);
    wait_idle("cw3", 400);
    chk("cw3_ab", int'({sa, sb}), 0);

    // simultaneous cw and ccw cancel out
    pulse(1'b1, 1'b1, 1);
    repeat (20) @(negedge clk);
    chk("both_pend", int'($signed(pending)), 0);
    chk("both_busy", int'(busy), 0);
    chk("both_ovf", int'(overflow), 0);

    // saturation at +3 with PEND_W=3
    push_detents(3, 1'b1);
    pulse(1'b1, 1'b0, 5);
    @(negedge clk);
    chk("sat_pend", int'($signed(pending)), 3);
    chk("sat_ovf", int'(overflow), 1);
    @(posedge clk);
    #1 ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovfclr_ovf", int'(overflow), 0);
    chk("ovfclr_pend", int'($signed(pending)), 3);
    wait_idle("sat", 400);
    chk("sat_ovf_end", int'(overflow), 0);

    // reset while mid-detent at {sa,sb}=11 discards everything
    push_edge(2'b10, 1'b1, EDGE_DIV + 2, EDGE_DIV + 2);
    push_edge(2'b11, 1'b0, EDGE_DIV, EDGE_DIV);
    pulse(1'b1, 1'b0, 2);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if ({sa, sb} == 2'b11) break;
    end
    chk("rst_reach_11", int'({sa, sb}), 3);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_ab", int'({sa, sb}), 0);
    chk("rst_mid_pend", int'($signed(pending)), 0);
    chk("rst_mid_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_mid_edges_left", exp_q.size(), 0);
    repeat (20) @(negedge clk);
    chk("rst_after_busy", int'(busy), 0);
    chk("rst_after_pend", int'($signed(pending)), 0);

    // button stretcher, then a re-press that restarts the count
    press_test("press_8", 0, 8);
    press_test("repress_13", 5, 13);

    // loopback: two clockwise detents decode as two right turns
    r0 = rights; l0 = lefts;
    push_detents(2, 1'b1);
    pulse(1'b1, 1'b0, 2);
    wait_idle("loop", 300);
    chk("loop_right", rights - r0, 2);
    chk("loop_left", lefts - l0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
